// File: rtl/byte_lane_data_memory.sv
// byte_lane_data_memory: word-organised data memory for the MEM stage.
// Stores write only the addressed byte lanes. Loads select the addressed lane
// and sign- or zero-extend it. Requests use valid/ready and each accepted
// request gets one registered response pulse. After reset the array is
// cleared one word per cycle, and no requests are accepted until that sweep
// has finished.
// Optional feature macro: DMEM_FAULT_CHECK_EN. When it is defined, misaligned,
// out-of-range and illegal-func3 requests are reported on resp_fault. When it
// is undefined (the legacy mode), resp_fault stays 0, misaligned accesses are
// truncated to their natural alignment and the word index wraps.
module byte_lane_data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);
    localparam int unsigned        INDEX_W  = $clog2(DEPTH_WORDS);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH_WORDS - 1);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [INDEX_W-1:0] sweep_idx_r;
    logic [INDEX_W-1:0] sweep_idx_next_s;
    logic [31:0]        mem_r [DEPTH_WORDS];

    logic [31:0]        off_s;
    logic [1:0]         lane_s;
    logic [1:0]         eff_lane_s;
    logic [INDEX_W-1:0] idx_s;
    logic               range_err_s;
    logic               misalign_s;
    logic               illegal_s;
    logic               fault_s;
    logic               accept_s;
    logic               store_s;
    logic [3:0]         be_s;
    logic [31:0]        wlane_s;
    logic [31:0]        word_s;
    logic [7:0]         byte_s;
    logic [15:0]        half_s;
    logic [31:0]        load_s;
    logic [31:0]        rdata_next_s;
    logic               unused_s;

    // Sweep state and counter register; reset restarts the clear sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            sweep_idx_r <= {INDEX_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            sweep_idx_r <= sweep_idx_next_s;
        end
    end

    // Next-state logic: step through every word once, then serve requests.
    always_comb begin
        state_next_s     = state_r;
        sweep_idx_next_s = sweep_idx_r;
        case (state_r)
            ST_CLEAR: begin
                sweep_idx_next_s = sweep_idx_r + INDEX_W'(1);
                if (sweep_idx_r == LAST_IDX) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_next_s     = ST_READY;
                sweep_idx_next_s = {INDEX_W{1'b0}};
            end
            default: begin
                state_next_s     = ST_CLEAR;
                sweep_idx_next_s = {INDEX_W{1'b0}};
            end
        endcase
    end

    assign req_ready = (state_r == ST_READY);
    assign accept_s  = req_valid && (state_r == ST_READY);
    assign unused_s  = ^off_s[31:INDEX_W+2];

    // Address decode, fault classification and effective lane selection.
    always_comb begin
        off_s       = req_address - BASE_ADDR;
        lane_s      = off_s[1:0];
        idx_s       = off_s[INDEX_W+1:2];
        range_err_s = |off_s[31:INDEX_W+2];
        misalign_s  = 1'b0;
        illegal_s   = 1'b0;
        eff_lane_s  = lane_s;
        case (req_func3)
            3'b000, 3'b100: begin
                misalign_s = 1'b0;
                eff_lane_s = lane_s;
            end
            3'b001, 3'b101: begin
                misalign_s = lane_s[0];
                eff_lane_s = {lane_s[1], 1'b0};
            end
            3'b010: begin
                misalign_s = |lane_s;
                eff_lane_s = 2'b00;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
`ifdef DMEM_FAULT_CHECK_EN
        fault_s = range_err_s | misalign_s | illegal_s;
`else
        fault_s = 1'b0;
`endif
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be_s    = 4'b0000;
        wlane_s = 32'h0000_0000;
        case (req_func3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << eff_lane_s;
                wlane_s = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << eff_lane_s;
                wlane_s = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wlane_s = req_wdata;
            end
            default: begin
                be_s    = 4'b0000;
                wlane_s = 32'h0000_0000;
            end
        endcase
    end

    assign store_s = accept_s && req_write && !fault_s && !illegal_s;

    // Load path: pick the addressed lane and extend it per func3.
    always_comb begin
        word_s = mem_r[idx_s];
        byte_s = word_s[8*eff_lane_s +: 8];
        if (eff_lane_s[1]) begin
            half_s = word_s[31:16];
        end else begin
            half_s = word_s[15:0];
        end
        case (req_func3)
            3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  load_s = {24'h00_0000, byte_s};
            3'b001:  load_s = {{16{half_s[15]}}, half_s};
            3'b101:  load_s = {16'h0000, half_s};
            3'b010:  load_s = word_s;
            default: load_s = 32'h0000_0000;
        endcase
        if (accept_s && !req_write && !fault_s && !illegal_s) begin
            rdata_next_s = load_s;
        end else begin
            rdata_next_s = 32'h0000_0000;
        end
    end

    // Array write port: zero one word per cycle while sweeping, else byte-lane stores.
    always_ff @(posedge clock) begin
        if (!reset && (state_r == ST_CLEAR)) begin
            mem_r[sweep_idx_r] <= 32'h0000_0000;
        end else if (!reset && store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    // Registered one-cycle response for every accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= accept_s;
            resp_rdata <= rdata_next_s;
            resp_fault <= accept_s && fault_s;
        end
    end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Testbench for byte_lane_data_memory: directed scenarios plus randomized
// traffic compared against a byte-addressed reference model. Define
// DMEM_FAULT_CHECK_EN for both files to exercise the fault-reporting build.
module tb_byte_lane_data_memory;
    localparam int          DEPTH      = 1024;
    localparam int          BYTES      = DEPTH * 4;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam int          WAIT_LIMIT = DEPTH + 16;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int check_count;
    int pass_count;

    logic [7:0] ref_mem [0:BYTES-1];

    byte_lane_data_memory #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_func3   (req_func3),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte array accessed with the naturally sized access rules.
    task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic flt);
        int unsigned off;
        int unsigned ba;
        int          size;
        bit          illegal;
        logic [31:0] v;
        off     = addr - BASE;
        size    = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        rd  = 32'h0;
        flt = 1'b0;
`ifdef DMEM_FAULT_CHECK_EN
        if (illegal || off >= BYTES || (off % size) != 0) begin
            flt = 1'b1;
            return;
        end
        ba = off;
`else
        if (illegal) return;
        ba = ((off % BYTES) / size) * size;
`endif
        if (w) begin
            for (int i = 0; i < size; i++) ref_mem[ba + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[ba + i];
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endtask

    // Present one request (valid stays high afterwards for back-to-back use).
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] got, output logic gotf);
        logic [31:0] erd;
        logic        eflt;
        int          n;
        n = 0;
        while (!req_ready && n < WAIT_LIMIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!req_ready) check_value("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = w;
        req_func3   = f3;
        req_address = addr;
        req_wdata   = wd;
        @(posedge clock);
        #1;
        model_access(w, f3, addr, wd, erd, eflt);
        check_value("resp_valid", {31'd0, resp_valid}, 32'd1);
        check_value("resp_rdata", resp_rdata, erd);
        check_value("resp_fault", {31'd0, resp_fault}, {31'd0, eflt});
        got  = resp_rdata;
        gotf = resp_fault;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        check_value("idle_no_resp", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_value("rst_ready", {31'd0, req_ready}, 32'd0);
        check_value("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_value("rst_rdata", resp_rdata, 32'd0);
        check_value("rst_fault", {31'd0, resp_fault}, 32'd0);
    endtask

    task automatic wait_sweep();
        int n;
        n = 0;
        while (!req_ready && n < WAIT_LIMIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_value("sweep_len", n, DEPTH);
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] prior;
        logic        gotf;
        check_count = 0;
        pass_count  = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_func3   = 3'b000;
        req_address = 32'h0;
        req_wdata   = 32'h0;
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;

        pulse_reset();
        wait_sweep();
        issue(1'b0, 3'b010, BASE + 32'h0000_0ABC, 32'h0, got, gotf);
        check_value("lw_after_reset", got, 32'h0);
        idle_cycle();

        issue(1'b1, 3'b010, BASE + 32'h100, 32'h1122_3344, got, gotf);
        issue(1'b1, 3'b000, BASE + 32'h101, 32'h0000_00AA, got, gotf);
        issue(1'b0, 3'b010, BASE + 32'h100, 32'h0, got, gotf);
        check_value("sb_merge_lw", got, 32'h1122_AA44);
        issue(1'b0, 3'b000, BASE + 32'h101, 32'h0, got, gotf);
        check_value("lb_sext", got, 32'hFFFF_FFAA);
        issue(1'b0, 3'b100, BASE + 32'h101, 32'h0, got, gotf);
        check_value("lbu_zext", got, 32'h0000_00AA);
        idle_cycle();

        issue(1'b1, 3'b001, BASE + 32'h202, 32'h0000_8001, got, gotf);
        issue(1'b0, 3'b001, BASE + 32'h202, 32'h0, got, gotf);
        check_value("lh_sext", got, 32'hFFFF_8001);
        issue(1'b0, 3'b101, BASE + 32'h202, 32'h0, got, gotf);
        check_value("lhu_zext", got, 32'h0000_8001);
        issue(1'b0, 3'b010, BASE + 32'h200, 32'h0, got, gotf);
        check_value("sh_upper_lw", got, 32'h8001_0000);
        idle_cycle();

        issue(1'b1, 3'b010, BASE + 32'h10, 32'h0000_0005, got, gotf);
        issue(1'b0, 3'b010, BASE + 32'h10, 32'h0, got, gotf);
        check_value("b2b_load", got, 32'h0000_0005);
        idle_cycle();

        issue(1'b1, 3'b010, BASE, 32'hCAFE_0001, got, gotf);
        issue(1'b0, 3'b010, BASE + 32'h103, 32'h0, got, gotf);
`ifdef DMEM_FAULT_CHECK_EN
        check_value("misalign_fault", {31'd0, gotf}, 32'd1);
        check_value("misalign_rdata", got, 32'h0);
`endif
        issue(1'b0, 3'b010, BASE, 32'h0, prior, gotf);
        issue(1'b1, 3'b010, BASE + BYTES, 32'hDEAD_BEEF, got, gotf);
`ifdef DMEM_FAULT_CHECK_EN
        check_value("range_fault", {31'd0, gotf}, 32'd1);
`endif
        issue(1'b0, 3'b010, BASE, 32'h0, got, gotf);
`ifdef DMEM_FAULT_CHECK_EN
        check_value("range_no_write", got, prior);
`endif
        idle_cycle();

        for (int k = 0; k < 400; k++) begin
            int unsigned off;
            if ($urandom_range(0, 9) == 0) off = BYTES + $urandom_range(0, 63);
            else off = $urandom_range(0, 63);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), BASE + off, $urandom, got, gotf);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        pulse_reset();
        repeat (300) @(posedge clock);
        #1;
        check_value("mid_sweep_ready", {31'd0, req_ready}, 32'd0);
        pulse_reset();
        wait_sweep();
        issue(1'b1, 3'b010, BASE + 32'h40, 32'h1234_5678, got, gotf);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_func3   = 3'b010;
        req_address = BASE + 32'h40;
        reset       = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        check_value("pending_dropped", {31'd0, resp_valid}, 32'd0);
        wait_sweep();
        issue(1'b0, 3'b010, BASE + 32'h40, 32'h0, got, gotf);
        check_value("cleared_after_rst", got, 32'h0);
        idle_cycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/byte_lane_data_memory.md
Name: byte_lane_data_memory

Overview:
Parametrised successor to the core's data memory, sitting in the MEM stage of the processor core.
- Word array of configurable depth.
- Stores update only the addressed byte lanes, so SB/SH no longer clobber the rest of the word.
- Loads pick and extend the addressed lane.
- Valid/ready request interface, registered 1-cycle response, misalignment/range fault reporting.
- Reset clears the array with a one-word-per-cycle sweep rather than a single-cycle clear.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
INDEX_W, $clog2(DEPTH_WORDS), word index width (derived, not overridden).

Ports:
clock  input  1  system clock, all logic on the rising edge
reset  input  1  synchronous, active-high; starts the clear sweep
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = store, 0 = load
req_func3  input  3  RV32 func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_address  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle pulse, one per accepted request
resp_rdata  output  32  load result; 0 for stores and faults
resp_fault  output  1  valid with resp_valid; misaligned or out-of-range

Behaviour:
Reset and outputs
- All outputs reset to 0.
- Sweep counter resets to 0, state CLEAR.

State machine
- CLEAR: writes 0 to word[counter] each cycle; req_ready = 0. Moves to READY after word DEPTH_WORDS-1, i.e. DEPTH_WORDS cycles after reset deasserts.
- READY: req_ready = 1 every cycle; back-to-back requests accepted.
- Reset asserted in any state, including mid-sweep or with a response pending: counter back to 0, state CLEAR, pending resp_valid dropped.

Address decode
- off = req_address - BASE_ADDR; idx = off[INDEX_W+1:2]; lane = off[1:0].
- Range fault: off >= DEPTH_WORDS*4.
- Misalign fault: H/HU with lane[0] = 1, or W with lane != 0.
- func3 011, 110, 111: fault.

Stores (accepted, no fault)
- B: byte lane ← wdata[7:0].
- H: lanes lane, lane+1 ← wdata[15:0].
- W: whole word.
- Other bytes unchanged.
- Written at the accept edge.
- Faulting store: no array change.

Loads
- Array read at the accept edge. Byte or halfword selected by lane.
- B/H: sign-extended. BU/HU: zero-extended. W: whole word.

Response
- resp_valid, resp_rdata, resp_fault are registered, asserted the cycle after accept, for exactly 1 cycle.
- No response backpressure; the consumer must take every response.

Ordering
- Load to the same word in the cycle after a store returns the stored data.
- Request stream is processed strictly in order; no reordering or merging.

Optional Feature:
DMEM_FAULT_CHECK_EN
- Defined: range and misalignment faults as above.
- Undefined: resp_fault tied 0.
  - Misaligned H: treated as lane & 2'b10.
  - Misaligned W: treated as lane 0.
  - Out-of-range index wraps modulo DEPTH_WORDS.
  - This is the legacy core-compatible mode.

Test Plan:
1. Reset held 1 cycle → req_ready stays 0 for DEPTH_WORDS cycles, then 1. LW of any address after that → 0.
2. SW 0x100 ← 0x11223344, then SB 0x101 ← 0xAA. LW 0x100 → 0x1122AA44. LB 0x101 → 0xFFFFFFAA. LBU 0x101 → 0x000000AA.
3. SH 0x202 ← 0x8001. LH 0x202 → 0xFFFF8001. LHU 0x202 → 0x00008001. LW 0x200 → 0x80010000.
4. FAULT_CHECK_EN: LW 0x103 → resp_fault = 1, rdata 0. SW to BASE_ADDR + DEPTH_WORDS*4 → fault, array unchanged (check with a prior read).
5. Back-to-back: SW 0x10 ← 5 then LW 0x10 on consecutive cycles → two resp_valid pulses, second returns 5.
6. Reset asserted mid-sweep (cycle 300) and again with a load pending → no resp_valid, sweep restarts, full DEPTH_WORDS cycles until req_ready.
